// File: rtl/axi4_video_frame_checker_pkg.sv
// -----------------------------------------------------------------------------
// axi4_video_frame_checker_pkg
//   Shared types and helpers for the AXI4-Stream video frame checker.
//   - state_e      : frame tracking state (waiting for SOF / inside a frame)
//   - err_evt_t    : single-cycle error events, one bit per error class
//   - cnt_width_req: minimum counter width needed for a given geometry
// -----------------------------------------------------------------------------
package axi4_video_frame_checker_pkg;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_e;

    typedef struct packed {
        logic line_len;
        logic frame_len;
    } err_evt_t;

    // The pixel counter must reach X_ACTIVE, and the line counter must reach
    // Y_ACTIVE+1 so that a line overrun is still distinguishable.
    function automatic int unsigned cnt_width_req(input int unsigned x_active,
                                                  input int unsigned y_active);
        int unsigned max_val;
        max_val = (x_active > y_active + 1) ? x_active : y_active + 1;
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/axi4_video_chk_err_lock.sv
// -----------------------------------------------------------------------------
// axi4_video_chk_err_lock
//   Sticky error flags and frame-lock tracking for the video frame checker.
//   Ports:
//     clk_i, rst_i      : clock, asynchronous active-high reset
//     err_evt_i         : error events detected on this cycle's beat
//     good_frame_i      : a frame has just closed cleanly
//     clr_err_i         : clears the sticky flags (an event on the same edge wins)
//     err_line_len_o    : sticky line-width error
//     err_frame_len_o   : sticky frame-height error
//     locked_o          : LOCK_FRAMES consecutive good frames since last error
// -----------------------------------------------------------------------------
module axi4_video_chk_err_lock
    import axi4_video_frame_checker_pkg::*;
#(
    parameter int LOCK_FRAMES = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  err_evt_t err_evt_i,
    input  logic     good_frame_i,
    input  logic     clr_err_i,
    output logic     err_line_len_o,
    output logic     err_frame_len_o,
    output logic     locked_o
);

    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_FRAMES);

    logic              err_line_len_q, err_line_len_d;
    logic              err_frame_len_q, err_frame_len_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic              locked_q, locked_d;
    logic              any_evt;

    assign any_evt = err_evt_i.line_len | err_evt_i.frame_len;

    always_comb begin
        // Clear first, then OR in the event so a coincident event keeps the flag.
        err_line_len_d  = (err_line_len_q  & ~clr_err_i) | err_evt_i.line_len;
        err_frame_len_d = (err_frame_len_q & ~clr_err_i) | err_evt_i.frame_len;

        good_cnt_d = good_cnt_q;
        if (any_evt) begin
            good_cnt_d = '0;
        end else if (good_frame_i && good_cnt_q != GOOD_MAX) begin
            good_cnt_d = good_cnt_q + 1'b1;
        end
        locked_d = (good_cnt_d == GOOD_MAX);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_line_len_q  <= 1'b0;
            err_frame_len_q <= 1'b0;
            good_cnt_q      <= '0;
            locked_q        <= 1'b0;
        end else begin
            err_line_len_q  <= err_line_len_d;
            err_frame_len_q <= err_frame_len_d;
            good_cnt_q      <= good_cnt_d;
            locked_q        <= locked_d;
        end
    end

    assign err_line_len_o  = err_line_len_q;
    assign err_frame_len_o = err_frame_len_q;
    assign locked_o        = locked_q;

endmodule

// File: rtl/axi4_video_frame_checker.sv
// -----------------------------------------------------------------------------
// axi4_video_frame_checker
//   Passive AXI4-Stream video checker: measures line width and frame height,
//   counts frames, flags geometry errors and reports lock. No data path.
//   Ports:
//     clk_i, rst_i          : clock, asynchronous active-high reset
//     video_i_*             : AXI4-Stream video input (tuser=SOF, tlast=EOL)
//     video_i_tready        : 0 in reset, 1 from the first edge after release
//     clr_err_i             : pulse that clears the sticky error flags
//     frame_cnt_o           : SOF beats accepted (wraps)
//     line_width_o          : pixel count of the last completed line
//     frame_height_o        : line count of the last completed frame
//     err_line_len_o        : sticky line-width error
//     err_frame_len_o       : sticky frame-height error
//     locked_o              : stream locked to the expected geometry
// -----------------------------------------------------------------------------
module axi4_video_frame_checker
    import axi4_video_frame_checker_pkg::*;
#(
    parameter int X_ACTIVE    = 1920,
    parameter int Y_ACTIVE    = 1080,
    parameter int CNT_WIDTH   = 16,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          video_i_tdata,
    input  logic                 video_i_tvalid,
    input  logic                 video_i_tlast,
    input  logic                 video_i_tuser,
    output logic                 video_i_tready,
    input  logic                 clr_err_i,
    output logic [31:0]          frame_cnt_o,
    output logic [CNT_WIDTH-1:0] line_width_o,
    output logic [CNT_WIDTH-1:0] frame_height_o,
    output logic                 err_line_len_o,
    output logic                 err_frame_len_o,
    output logic                 locked_o
);

    if (CNT_WIDTH < int'(cnt_width_req(X_ACTIVE, Y_ACTIVE))) begin : g_cnt_width_check
        $error("CNT_WIDTH too small for X_ACTIVE/Y_ACTIVE");
    end

    localparam logic [CNT_WIDTH-1:0] X_CNT  = CNT_WIDTH'(X_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] X_LAST = CNT_WIDTH'(X_ACTIVE - 1);
    localparam logic [CNT_WIDTH-1:0] Y_CNT  = CNT_WIDTH'(Y_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] Y_OVER = CNT_WIDTH'(Y_ACTIVE + 1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] px_cnt_q, px_cnt_d;
    logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic [31:0]          frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] line_width_q, line_width_d;
    logic [CNT_WIDTH-1:0] frame_height_q, frame_height_d;
    logic                 frame_err_q, frame_err_d;   // error seen inside the open frame
    logic                 ready_q;

    logic                 beat;
    logic                 in_frame;
    logic [CNT_WIDTH-1:0] px_base, line_base, px_next, line_next;
    logic                 frame_err_base;
    err_evt_t             close_evt, pix_evt, err_evt;
    logic                 good_frame;
    logic                 unused_tdata;

    assign unused_tdata = ^video_i_tdata;
    assign beat         = video_i_tvalid & ready_q;

    // A tuser beat first closes the running frame (if any), then is processed
    // as the first pixel of a fresh frame using zeroed counter bases.
    always_comb begin
        // NOTE: every combinational output gets a default here so no path
        // leaves a signal unassigned and infers a latch.
        state_d        = state_q;
        px_cnt_d       = px_cnt_q;
        line_cnt_d     = line_cnt_q;
        frame_cnt_d    = frame_cnt_q;
        line_width_d   = line_width_q;
        frame_height_d = frame_height_q;
        frame_err_d    = frame_err_q;
        close_evt      = '0;
        pix_evt        = '0;
        good_frame     = 1'b0;
        in_frame       = 1'b0;
        px_base        = px_cnt_q;
        line_base      = line_cnt_q;
        frame_err_base = frame_err_q;
        px_next        = '0;
        line_next      = '0;

        if (beat) begin
            if (video_i_tuser) begin
                if (state_q == ACTIVE) begin
                    frame_height_d      = line_cnt_q;
                    close_evt.line_len  = (px_cnt_q != '0);
                    close_evt.frame_len = (line_cnt_q != Y_CNT);
                    good_frame = (px_cnt_q == '0) && (line_cnt_q == Y_CNT) && !frame_err_q;
                end
                frame_cnt_d    = frame_cnt_q + 32'd1;
                state_d        = ACTIVE;
                in_frame       = 1'b1;
                px_base        = '0;
                line_base      = '0;
                frame_err_base = 1'b0;
            end else if (state_q == ACTIVE) begin
                in_frame = 1'b1;
            end

            if (in_frame) begin
                px_next = sat_inc(px_base);
                if (video_i_tlast) begin
                    line_width_d      = px_next;
                    pix_evt.line_len  = (px_next != X_CNT);
                    line_next         = sat_inc(line_base);
                    pix_evt.frame_len = (line_next == Y_OVER);
                    line_cnt_d        = line_next;
                    px_cnt_d          = '0;
                end else begin
                    // The X_ACTIVE-th pixel arrived without tlast.
                    pix_evt.line_len = (px_base == X_LAST);
                    px_cnt_d         = px_next;
                    line_cnt_d       = line_base;
                end
                frame_err_d = frame_err_base | pix_evt.line_len | pix_evt.frame_len;
            end
        end
    end

    assign err_evt = err_evt_t'(close_evt | pix_evt);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= WAIT_SOF;
            px_cnt_q       <= '0;
            line_cnt_q     <= '0;
            frame_cnt_q    <= '0;
            line_width_q   <= '0;
            frame_height_q <= '0;
            frame_err_q    <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            px_cnt_q       <= px_cnt_d;
            line_cnt_q     <= line_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            line_width_q   <= line_width_d;
            frame_height_q <= frame_height_d;
            frame_err_q    <= frame_err_d;
            ready_q        <= 1'b1;
        end
    end

    axi4_video_chk_err_lock #(
        .LOCK_FRAMES (LOCK_FRAMES)
    ) u_err_lock (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .err_evt_i       (err_evt),
        .good_frame_i    (good_frame),
        .clr_err_i       (clr_err_i),
        .err_line_len_o  (err_line_len_o),
        .err_frame_len_o (err_frame_len_o),
        .locked_o        (locked_o)
    );

    assign video_i_tready = ready_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign line_width_o   = line_width_q;
    assign frame_height_o = frame_height_q;

endmodule
